// File: rtl/sha_msg_padder_pkg.sv
// Shared types and helpers for the SHA message padder: algorithm modes,
// padder FSM states and per-mode block geometry.
package sha_msg_padder_pkg;

  typedef enum logic [2:0] {
    sha1       = 3'd0,
    sha224     = 3'd1,
    sha256     = 3'd2,
    sha384     = 3'd3,
    sha512     = 3'd4,
    sha512_224 = 3'd5,
    sha512_256 = 3'd6
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND_DATA,
    ST_PAD,
    ST_SEND_PAD1,
    ST_SEND_FINAL
  } pad_state_t;

  localparam int SHA_MAX_BLOCK_W     = 1024;
  localparam int SHA_MAX_BLOCK_BYTES = SHA_MAX_BLOCK_W / 8;
  localparam int SHA_MAX_LEN_W       = 128;

  // True for the SHA-384/512 family, which works on 1024-bit blocks.
  function automatic logic is_1024(input mode_t mode);
    case (mode)
      sha384, sha512, sha512_224, sha512_256: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Bytes per block for the given mode.
  function automatic logic [7:0] block_bytes(input mode_t mode);
    return is_1024(mode) ? 8'd128 : 8'd64;
  endfunction

  // Bytes taken by the big-endian message length field at the block tail.
  function automatic logic [7:0] len_bytes(input mode_t mode);
    return is_1024(mode) ? 8'd16 : 8'd8;
  endfunction

endpackage

// File: rtl/sha_msg_padder_pad_insert.sv
// Combinational padding stage. The buffer is byte-ordered: byte i of the
// block sits at bits [1023-8i -: 8] regardless of mode. It can drop the
// 0x80 marker at the byte pointer (clearing everything after it) and/or
// write the bit length into the tail of the block.
module sha_pad_insert
  import sha_msg_padder_pkg::*;
(
  input  logic [SHA_MAX_BLOCK_W-1:0] blk_in,
  input  logic [7:0]                 ptr,
  input  mode_t                      mode,
  input  logic                       marker_en,
  input  logic                       len_en,
  input  logic [SHA_MAX_LEN_W-1:0]   len,
  output logic [SHA_MAX_BLOCK_W-1:0] blk_out
);

  localparam logic [SHA_MAX_BLOCK_W-1:0] ALL_ONES    = '1;
  localparam logic [SHA_MAX_BLOCK_W-1:0] MARKER_AT_0 = {8'h80, {(SHA_MAX_BLOCK_W-8){1'b0}}};

  logic [10:0] bit_off;

  assign bit_off = {ptr, 3'b000};

  // Marker and zero fill first, then the length field overwrites the tail.
  always_comb begin
    blk_out = blk_in;
    if (marker_en) begin
      blk_out = (blk_out & ~(ALL_ONES >> bit_off)) | (MARKER_AT_0 >> bit_off);
    end
    if (len_en) begin
      if (is_1024(mode)) begin
        blk_out[127:0] = len;
      end else begin
        blk_out[575:512] = len[63:0];
      end
    end
  end

endmodule

// File: rtl/sha_msg_padder.sv
// Streaming SHA message padder: collects big-endian byte beats into a block
// buffer, applies the 0x80 / zero / length padding and hands complete
// 512- or 1024-bit blocks to the hash engine.
module sha_msg_padder
  import sha_msg_padder_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic [DATA_W/8-1:0]        s_keep,
  input  logic                       s_last,
  input  mode_t                      s_mode,
  output logic                       m_new_msg,
  output logic                       m_valid,
  output mode_t                      m_mode,
  output logic [SHA_MAX_BLOCK_W-1:0] m_msg,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       err
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int BLK_W  = SHA_MAX_BLOCK_W;

  pad_state_t state_q, state_d;

  logic [BLK_W-1:0]         blk_q;
  logic [7:0]               ptr_q;
  logic [LEN_W-1:0]         len_q;
  mode_t                    mode_q;
  logic                     first_q;
  logic                     pending_q;
  logic                     err_q;

  mode_t                    cur_mode;
  logic [7:0]               cur_blk;
  logic [7:0]               nbytes;
  logic [7:0]               new_ptr;
  logic [KEEP_W-1:0]        keep_inv;
  logic [DATA_W-1:0]        keep_exp;
  logic                     keep_prefix;
  logic                     keep_full;
  logic                     room_ok;
  logic                     beat_fire;
  logic                     beat_bad;
  logic                     beat_ok;
  logic [BLK_W-1:0]         beat_blk;
  logic [BLK_W-1:0]         beat_mask;
  logic [BLK_W-1:0]         merged_blk;
  logic                     blk_xfer;

  logic                     pad_fits;
  logic [BLK_W-1:0]         pad_in;
  logic [7:0]               pad_ptr;
  logic                     pad_marker;
  logic                     pad_len;
  logic [BLK_W-1:0]         pad_out;
  logic [SHA_MAX_LEN_W-1:0] len_field;

  assign blk_xfer  = m_valid && m_ready;
  assign len_field = SHA_MAX_LEN_W'(len_q);

  // Decode the incoming beat: byte count, keep legality and where it lands.
  always_comb begin
    cur_mode = (state_q == ST_IDLE) ? s_mode : mode_q;
    cur_blk  = block_bytes(cur_mode);
    nbytes   = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      nbytes = nbytes + {7'd0, s_keep[i]};
    end
    keep_inv    = ~s_keep;
    keep_prefix = ((keep_inv & (keep_inv + KEEP_W'(1))) == '0);
    keep_full   = &s_keep;
    new_ptr     = ptr_q + nbytes;
    room_ok     = (new_ptr <= cur_blk);
    beat_fire   = s_valid && s_ready;
    beat_bad    = !keep_prefix || (!keep_full && !s_last) || !room_ok;
    beat_ok     = beat_fire && !beat_bad;
    keep_exp    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      keep_exp[i] = s_keep[i/8];
    end
    beat_blk   = {s_data & keep_exp, {(BLK_W-DATA_W){1'b0}}} >> {ptr_q, 3'b000};
    beat_mask  = {keep_exp, {(BLK_W-DATA_W){1'b0}}} >> {ptr_q, 3'b000};
    merged_blk = (blk_q & ~beat_mask) | beat_blk;
  end

  // Choose what the padding stage works on: the live buffer in PAD, or an
  // empty block when building the trailing extra block.
  always_comb begin
    pad_fits   = (ptr_q <= (block_bytes(mode_q) - len_bytes(mode_q) - 8'd1));
    pad_in     = blk_q;
    pad_ptr    = ptr_q;
    pad_marker = 1'b0;
    pad_len    = 1'b0;
    if (state_q == ST_PAD) begin
      pad_marker = (ptr_q < block_bytes(mode_q));
      pad_len    = pad_fits;
    end else if (state_q == ST_SEND_PAD1) begin
      pad_in     = '0;
      pad_ptr    = '0;
      pad_marker = pending_q;
      pad_len    = 1'b1;
    end
  end

  sha_pad_insert u_pad_insert (
    .blk_in    (pad_in),
    .ptr       (pad_ptr),
    .mode      (mode_q),
    .marker_en (pad_marker),
    .len_en    (pad_len),
    .len       (len_field),
    .blk_out   (pad_out)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (beat_ok) begin
          if (s_last) begin
            state_d = ST_PAD;
          end else if (new_ptr == cur_blk) begin
            state_d = ST_SEND_DATA;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_SEND_DATA: begin
        if (blk_xfer) state_d = ST_FILL;
      end
      ST_PAD: begin
        state_d = pad_fits ? ST_SEND_FINAL : ST_SEND_PAD1;
      end
      ST_SEND_PAD1: begin
        if (blk_xfer) state_d = ST_SEND_FINAL;
      end
      ST_SEND_FINAL: begin
        if (blk_xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; 512-bit modes present the low half of the block bus.
  always_comb begin
    s_ready   = !rst && ((state_q == ST_IDLE) || (state_q == ST_FILL));
    m_valid   = (state_q == ST_SEND_DATA) || (state_q == ST_SEND_PAD1) ||
                (state_q == ST_SEND_FINAL);
    busy      = (state_q != ST_IDLE);
    m_new_msg = first_q;
    m_mode    = mode_q;
    err       = err_q;
    if (is_1024(mode_q)) begin
      m_msg = blk_q;
    end else begin
      m_msg = {{(BLK_W/2){1'b0}}, blk_q[BLK_W-1 -: BLK_W/2]};
    end
  end

  // Datapath: buffer, byte pointer, bit length, latched mode and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q     <= '0;
      ptr_q     <= '0;
      len_q     <= '0;
      mode_q    <= sha1;
      first_q   <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= beat_fire && beat_bad;
      case (state_q)
        ST_IDLE, ST_FILL: begin
          if (beat_ok) begin
            blk_q <= merged_blk;
            ptr_q <= new_ptr;
            len_q <= len_q + LEN_W'({nbytes, 3'b000});
            if (state_q == ST_IDLE) begin
              mode_q  <= s_mode;
              first_q <= 1'b1;
            end
          end
        end
        ST_SEND_DATA: begin
          if (blk_xfer) begin
            blk_q   <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
          end
        end
        ST_PAD: begin
          blk_q     <= pad_out;
          pending_q <= !pad_marker;
        end
        ST_SEND_PAD1: begin
          if (blk_xfer) begin
            blk_q     <= pad_out;
            first_q   <= 1'b0;
            pending_q <= 1'b0;
          end
        end
        ST_SEND_FINAL: begin
          if (blk_xfer) begin
            blk_q   <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            first_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Self-checking bench for sha_msg_padder: directed and random messages are
// compared block by block against a byte-queue FIPS 180-4 padding model.
module tb_sha_msg_padder;
  import sha_msg_padder_pkg::*;

  localparam int DATA_W = 64;
  localparam int KW     = DATA_W / 8;

  typedef logic [7:0]    byte_q_t[$];
  typedef logic [1023:0] blk_q_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [KW-1:0]     s_keep;
  logic              s_last;
  mode_t             s_mode;
  logic              m_new_msg;
  logic              m_valid;
  mode_t             m_mode;
  logic [1023:0]     m_msg;
  logic              m_ready;
  logic              busy;
  logic              err;

  int     checks = 0;
  int     passed = 0;
  int     fails  = 0;
  blk_q_t rcv_q;

  sha_msg_padder #(.DATA_W(DATA_W), .LEN_W(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .s_mode    (s_mode),
    .m_new_msg (m_new_msg),
    .m_valid   (m_valid),
    .m_mode    (m_mode),
    .m_msg     (m_msg),
    .m_ready   (m_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Wide comparison; reports the first differing 64-bit slice.
  task automatic checkOutput(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int c;
    c = 0;
    for (int i = 15; i >= 0; i--) begin
      if (obs[i*64 +: 64] !== exp[i*64 +: 64]) c = i;
    end
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s bits[%0d:%0d] observed=%h expected=%h",
             tag, c*64+63, c*64, obs[c*64 +: 64], exp[c*64 +: 64]);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to the length slot, big-endian bit length.
  function automatic blk_q_t padModel(input byte_q_t msg, input mode_t mode);
    byte_q_t       p;
    blk_q_t        res;
    int            blk;
    int            lb;
    logic [127:0]  bitlen;
    logic [1023:0] v;
    case (mode)
      sha1, sha224, sha256: begin blk = 64;  lb = 8;  end
      default:              begin blk = 128; lb = 16; end
    endcase
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % blk) != (blk - lb)) p.push_back(8'h00);
    bitlen = 128'(msg.size()) * 128'd8;
    for (int k = lb - 1; k >= 0; k--) p.push_back(bitlen[k*8 +: 8]);
    for (int b = 0; b < p.size() / blk; b++) begin
      v = '0;
      for (int j = 0; j < blk; j++) v[(blk*8 - 1 - 8*j) -: 8] = p[b*blk + j];
      res.push_back(v);
    end
    return res;
  endfunction

  function automatic byte_q_t randMsg(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  function automatic byte_q_t helloMsg();
    byte_q_t q;
    string   s;
    s = "Hello World!";
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic packBeat(input byte_q_t msg, input int b, output logic [DATA_W-1:0] d, output logic [KW-1:0] k);
    d = '0;
    k = '0;
    for (int j = 0; j < KW; j++) begin
      if (b*KW + j < msg.size()) begin
        d[DATA_W-1-8*j -: 8] = msg[b*KW + j];
        k[KW-1-j] = 1'b1;
      end
    end
  endtask

  // One beat transfer; starts and ends on a falling edge.
  task automatic sendBeat(input logic [DATA_W-1:0] d, input logic [KW-1:0] k, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    while (!s_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkBit("s_ready_wait", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic applyStimulus(input byte_q_t msg, input mode_t mode, input int start_beat);
    int                nbeats;
    logic [DATA_W-1:0] d;
    logic [KW-1:0]     k;
    s_mode = mode;
    nbeats = (msg.size() == 0) ? 1 : (msg.size() + KW - 1) / KW;
    for (int b = start_beat; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      packBeat(msg, b, d, k);
      sendBeat(d, k, b == nbeats - 1);
    end
  endtask

  task automatic collectBlocks(input blk_q_t exp, input mode_t mode, input int hold);
    int n;
    int h;
    for (int b = 0; b < exp.size(); b++) begin
      n = 0;
      while (!m_valid && n < 400) begin
        @(negedge clk);
        n++;
      end
      checkBit("m_valid_wait", m_valid, 1'b1);
      h = (hold < 0) ? $urandom_range(0, 2) : hold;
      for (int i = 0; i < h; i++) begin
        checkOutput("hold_msg", m_msg, exp[b]);
        checkBit("hold_s_ready", s_ready, 1'b0);
        @(negedge clk);
        checkBit("hold_m_valid", m_valid, 1'b1);
      end
      checkOutput($sformatf("block%0d_msg", b), m_msg, exp[b]);
      checkBit($sformatf("block%0d_new_msg", b), m_new_msg, b == 0);
      checkOutput("block_mode", 1024'(m_mode), 1024'(mode));
      rcv_q.push_back(m_msg);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
  endtask

  task automatic runMessage(input byte_q_t msg, input mode_t mode, input int hold, input int start_beat);
    blk_q_t exp;
    exp = padModel(msg, mode);
    rcv_q.delete();
    fork
      applyStimulus(msg, mode, start_beat);
      collectBlocks(exp, mode, hold);
    join
    checkBit("busy_after_msg", busy, 1'b0);
    checkOutput("block_count", 1024'(rcv_q.size()), 1024'(exp.size()));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t           msg;
    logic [DATA_W-1:0] d;
    logic [KW-1:0]     k;
    logic [1023:0]     blk;
    mode_t             mode;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    s_mode  = sha1;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkBit("s_ready_in_reset", s_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkBit("reset_s_ready", s_ready, 1'b1);
    checkBit("reset_m_valid", m_valid, 1'b0);
    checkBit("reset_new_msg", m_new_msg, 1'b0);
    checkOutput("reset_mode", 1024'(m_mode), 1024'(sha1));
    checkOutput("reset_msg", m_msg, 1024'(0));
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_err", err, 1'b0);

    msg = helloMsg();
    runMessage(msg, sha256, -1, 0);
    blk = rcv_q[0];
    checkOutput("hello256_text", 1024'(blk[511:416]), 1024'(96'h48656c6c6f20576f726c6421));
    checkOutput("hello256_marker", 1024'(blk[415:408]), 1024'(8'h80));
    checkOutput("hello256_len", 1024'(blk[63:0]), 1024'(64'h60));
    checkOutput("hello256_upper", 1024'(blk[1023:512]), 1024'(0));

    runMessage(msg, sha512, -1, 0);
    blk = rcv_q[0];
    checkOutput("hello512_marker", 1024'(blk[927:920]), 1024'(8'h80));
    checkOutput("hello512_len", 1024'(blk[127:0]), 1024'(128'h60));

    msg.delete();
    runMessage(msg, sha256, -1, 0);
    blk = rcv_q[0];
    checkOutput("empty256_block", 1024'(blk[511:0]), 1024'({8'h80, 440'h0, 64'h0}));

    msg = randMsg(56);
    runMessage(msg, sha256, -1, 0);
    blk = rcv_q[1];
    checkOutput("len56_second_block", blk, 1024'(64'h1C0));

    msg = randMsg(128);
    runMessage(msg, sha512, 5, 0);
    blk = rcv_q[1];
    checkOutput("len128_extra_block", blk, {8'h80, 888'h0, 128'h400});

    msg = randMsg(20);
    s_mode = sha256;
    packBeat(msg, 0, d, k);
    sendBeat(d, k, 1'b0);
    sendBeat(64'hDEAD_BEEF_0BAD_F00D, 8'b1011_0000, 1'b0);
    checkBit("err_nonprefix", err, 1'b1);
    checkBit("err_busy", busy, 1'b1);
    @(negedge clk);
    checkBit("err_pulse_end", err, 1'b0);
    sendBeat(64'h1234_5678_9ABC_DEF0, 8'hF0, 1'b0);
    checkBit("err_partial_no_last", err, 1'b1);
    runMessage(msg, sha256, -1, 1);

    msg = randMsg(40);
    s_mode = sha512;
    packBeat(msg, 0, d, k);
    sendBeat(d, k, 1'b0);
    packBeat(msg, 1, d, k);
    sendBeat(d, k, 1'b0);
    checkBit("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkBit("abort_busy", busy, 1'b0);
    checkBit("abort_m_valid", m_valid, 1'b0);
    checkBit("abort_s_ready", s_ready, 1'b0);
    checkOutput("abort_msg", m_msg, 1024'(0));
    rst = 1'b0;
    @(negedge clk);
    checkBit("abort_s_ready_after", s_ready, 1'b1);
    msg = randMsg(30);
    runMessage(msg, sha256, -1, 0);

    for (int r = 0; r < 10; r++) begin
      mode = mode_t'($urandom_range(0, 6));
      msg  = randMsg($urandom_range(0, 200));
      runMessage(msg, mode, -1, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
